// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory port arbiter.
package dmem_arbiter_pkg;

    // Owner encoding of the pending-response register.
    localparam logic [1:0] PORT_P0   = 2'd0;
    localparam logic [1:0] PORT_P1   = 2'd1;
    localparam logic [1:0] PORT_NONE = 2'd3;

    // Byte enable of an idle cycle: no BRAM bank or IO strobe enabled.
    localparam logic [3:0] BE_NONE = 4'b0000;

    // One requester's access fields, as presented to the MMU.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        sgn;
    } dm_req_t;

    // Fields driven onto the MMU port while no access is granted.
    localparam dm_req_t DM_REQ_IDLE = '{
        we:    1'b0,
        addr:  32'h0,
        wdata: 32'h0,
        be:    BE_NONE,
        sgn:   1'b0
    };

endpackage

// File: rtl/dmem_arb_policy.sv
// Grant policy for the two-port data-memory arbiter.
// Default build: port 0 has priority and port 1 is protected by an aging
// counter that forces a port-1 win after MAX_WAIT consecutive denials.
// With DMEM_ARB_ROUND_ROBIN_EN defined: the aging counter is replaced by a
// last_winner flop and contended cycles alternate between the ports.
module dmem_arb_policy #(
    parameter int unsigned MAX_WAIT = 4,  // legal range 1 .. 2**WAIT_W-1
    parameter int unsigned WAIT_W   = 3
) (
    input  logic clk,
    input  logic resetb,
    input  logic p0_req,
    input  logic p1_req,
    output logic p0_gnt,
    output logic p1_gnt
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN

    // Set when port 1 won the most recent contended cycle.
    logic r_last_p1;

    // Contended cycles go to the port that did not win the last contention.
    always_comb begin
        p0_gnt = p0_req && (!p1_req || r_last_p1);
        p1_gnt = p1_req && (!p0_req || !r_last_p1);
    end

    // Only contended cycles move last_winner; reset favours port 0 first.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_last_p1 <= 1'b1;
        end else if (p0_req && p1_req) begin
            r_last_p1 <= !r_last_p1;
        end
    end

`else

    localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              w_p1_aged;

    // Fixed priority to port 0 unless port 1 has aged out.
    always_comb begin
        w_p1_aged = (r_wait_cnt == MaxWait);
        p0_gnt    = p0_req && !(p1_req && w_p1_aged);
        p1_gnt    = p1_req && !(p0_req && !w_p1_aged);
    end

    // Count consecutive port-1 denials; any grant or abandon restarts it.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_wait_cnt <= '0;
        end else if (!p1_req || p1_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != MaxWait) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single MMU data port between the load/store stage (port 0) and
// the boot loader / debug access unit (port 1). Grants are combinational;
// the MMU answers one clock later and the response is routed to the port
// recorded in the owner register. The grant policy lives in dmem_arb_policy;
// the optional macro DMEM_ARB_ROUND_ROBIN_EN selects round-robin contention.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned WAIT_W   = 3
) (
    input  logic        clk,
    input  logic        resetb,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_be,
    input  logic        p0_signed,
    output logic        p0_gnt,
    output logic        p0_rvalid,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_be,
    input  logic        p1_signed,
    output logic        p1_gnt,
    output logic        p1_rvalid,

    output logic [31:0] p_rdata,

    output logic        mmu_we,
    output logic [31:0] mmu_addr,
    output logic [31:0] mmu_di,
    output logic [3:0]  mmu_be,
    output logic        mmu_signed,
    input  logic [31:0] mmu_do
);

    logic [1:0] r_owner;
    logic       w_p0_gnt;
    logic       w_p1_gnt;
    dm_req_t    w_p0_fields;
    dm_req_t    w_p1_fields;
    dm_req_t    w_mmu;

    dmem_arb_policy #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_policy (
        .clk    (clk),
        .resetb (resetb),
        .p0_req (p0_req),
        .p1_req (p1_req),
        .p0_gnt (w_p0_gnt),
        .p1_gnt (w_p1_gnt)
    );

    assign p0_gnt = w_p0_gnt;
    assign p1_gnt = w_p1_gnt;

    // Pack requester fields so the mux below stays one assignment per source.
    always_comb begin
        w_p0_fields = '{we: p0_we, addr: p0_addr, wdata: p0_wdata, be: p0_be, sgn: p0_signed};
        w_p1_fields = '{we: p1_we, addr: p1_addr, wdata: p1_wdata, be: p1_be, sgn: p1_signed};
    end

    // Winner's fields go to the MMU untouched; idle cycles drive all-zero.
    always_comb begin
        w_mmu = DM_REQ_IDLE;
        if (w_p0_gnt) begin
            w_mmu = w_p0_fields;
        end else if (w_p1_gnt) begin
            w_mmu = w_p1_fields;
        end
    end

    assign mmu_we     = w_mmu.we;
    assign mmu_addr   = w_mmu.addr;
    assign mmu_di     = w_mmu.wdata;
    assign mmu_be     = w_mmu.be;
    assign mmu_signed = w_mmu.sgn;

    // Remember who was granted so next cycle's MMU data reaches that port.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_owner <= PORT_NONE;
        end else if (w_p0_gnt) begin
            r_owner <= PORT_P0;
        end else if (w_p1_gnt) begin
            r_owner <= PORT_P1;
        end else begin
            r_owner <= PORT_NONE;
        end
    end

    assign p0_rvalid = (r_owner == PORT_P0);
    assign p1_rvalid = (r_owner == PORT_P1);
    assign p_rdata   = mmu_do;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter. A small one-cycle-latency
// word memory stands in for the MMU. Inputs change 1 ns after the rising
// edge; outputs are sampled 1 ns later, well away from the edge.
// Build with DMEM_ARB_ROUND_ROBIN_EN defined to check the round-robin policy.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        resetb;
    logic        p0_req, p0_we, p0_signed, p0_gnt, p0_rvalid;
    logic [31:0] p0_addr, p0_wdata;
    logic [3:0]  p0_be;
    logic        p1_req, p1_we, p1_signed, p1_gnt, p1_rvalid;
    logic [31:0] p1_addr, p1_wdata;
    logic [3:0]  p1_be;
    logic [31:0] p_rdata;
    logic        mmu_we, mmu_signed;
    logic [31:0] mmu_addr, mmu_di, mmu_do;
    logic [3:0]  mmu_be;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .MAX_WAIT (4),
        .WAIT_W   (3)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .p0_req     (p0_req),
        .p0_we      (p0_we),
        .p0_addr    (p0_addr),
        .p0_wdata   (p0_wdata),
        .p0_be      (p0_be),
        .p0_signed  (p0_signed),
        .p0_gnt     (p0_gnt),
        .p0_rvalid  (p0_rvalid),
        .p1_req     (p1_req),
        .p1_we      (p1_we),
        .p1_addr    (p1_addr),
        .p1_wdata   (p1_wdata),
        .p1_be      (p1_be),
        .p1_signed  (p1_signed),
        .p1_gnt     (p1_gnt),
        .p1_rvalid  (p1_rvalid),
        .p_rdata    (p_rdata),
        .mmu_we     (mmu_we),
        .mmu_addr   (mmu_addr),
        .mmu_di     (mmu_di),
        .mmu_be     (mmu_be),
        .mmu_signed (mmu_signed),
        .mmu_do     (mmu_do)
    );

    // MMU stand-in: byte-enabled writes, reads return one clock later.
    always_ff @(posedge clk) begin
        if (mmu_be != 4'b0000) begin
            if (mmu_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mmu_be[b]) mem[mmu_addr[9:2]][8*b +: 8] <= mmu_di[8*b +: 8];
                end
                mmu_do <= 32'h0;
            end else begin
                mmu_do <= mem[mmu_addr[9:2]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h04] = 32'h1234_5678;  // word at 0x10000010
        mmu_do = 32'h0;

        // Reset held with both ports requesting.
        resetb = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h1000_0000; p0_wdata = 32'h0;
        p0_be = 4'hF; p0_signed = 1'b0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h1000_0010; p1_wdata = 32'h0;
        p1_be = 4'hF; p1_signed = 1'b0;
        repeat (3) cyc();
        check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        resetb = 1'b1;
        #1;
        check("rel_p0_gnt", 32'(p0_gnt), 32'd1);
        check("rel_p1_gnt", 32'(p1_gnt), 32'd0);
        cyc();
        check("rel_p0_rvalid", 32'(p0_rvalid), 32'd1);
        check("rel_p1_rvalid", 32'(p1_rvalid), 32'd0);

        // Idle: requester fields are live but nothing reaches the MMU.
        p0_req = 1'b0; p1_req = 1'b0;
        p0_we = 1'b1; p0_addr = 32'h8000_0000; p0_wdata = 32'hA5A5_A5A5; p0_signed = 1'b1;
        #1;
        check("idle_be", 32'(mmu_be), 32'd0);
        check("idle_we", 32'(mmu_we), 32'd0);
        check("idle_addr", mmu_addr, 32'h0);
        check("idle_di", mmu_di, 32'h0);
        check("idle_signed", 32'(mmu_signed), 32'd0);
        cyc();
        check("idle_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);

        // Solo read on port 1.
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h1000_0010; p1_be = 4'hF; p1_signed = 1'b1;
        #1;
        check("solo_p1_gnt", 32'(p1_gnt), 32'd1);
        check("solo_p0_gnt", 32'(p0_gnt), 32'd0);
        check("solo_addr", mmu_addr, 32'h1000_0010);
        check("solo_signed", 32'(mmu_signed), 32'd1);
        cyc();
        p1_req = 1'b0;
        check("solo_p1_rvalid", 32'(p1_rvalid), 32'd1);
        check("solo_rdata", p_rdata, 32'h1234_5678);

        // Port 0 writes, port 1 reads the same word the next cycle.
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h1000_0020; p0_wdata = 32'hDEAD_BEEF;
        p0_be = 4'hF; p0_signed = 1'b0;
        #1;
        check("wr_p0_gnt", 32'(p0_gnt), 32'd1);
        check("wr_mmu_we", 32'(mmu_we), 32'd1);
        check("wr_mmu_di", mmu_di, 32'hDEAD_BEEF);
        cyc();
        p0_req = 1'b0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h1000_0020; p1_be = 4'hF; p1_signed = 1'b0;
        #1;
        check("wr_p0_rvalid", 32'(p0_rvalid), 32'd1);
        check("rd_p1_gnt", 32'(p1_gnt), 32'd1);
        cyc();
        p1_req = 1'b0;
        check("rd_p1_rvalid", 32'(p1_rvalid), 32'd1);
        check("rd_p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("rd_rdata", p_rdata, 32'hDEAD_BEEF);

`ifndef DMEM_ARB_ROUND_ROBIN_EN
        // Abandon clears aging: two denials, drop p1, then a full 4-cycle wait.
        p0_req = 1'b1; p0_we = 1'b0; p1_req = 1'b1;
        cyc();
        cyc();
        p1_req = 1'b0;
        cyc();
        p1_req = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            check($sformatf("abandon_p1_gnt[%0d]", j), 32'(p1_gnt), (j == 4) ? 32'd1 : 32'd0);
            cyc();
        end
        p0_req = 1'b0; p1_req = 1'b0;
        cyc();
`endif

        // Async reset pulse to start contention from a known policy state.
        resetb = 1'b0;
        cyc();
        resetb = 1'b1;

        // Continuous contention.
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h1000_0020;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h1000_0010;
        for (int i = 0; i < 10; i++) begin
            logic exp_p1;
            logic prev_p1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            exp_p1  = (i % 2) == 1;
            prev_p1 = ((i - 1) % 2) == 1;
`else
            exp_p1  = (i == 4) || (i == 9);
            prev_p1 = (i == 5);
`endif
            #1;
            check($sformatf("cont_p0_gnt[%0d]", i), 32'(p0_gnt), 32'(!exp_p1));
            check($sformatf("cont_p1_gnt[%0d]", i), 32'(p1_gnt), 32'(exp_p1));
            if (i > 0) begin
                check($sformatf("cont_p1_rvalid[%0d]", i), 32'(p1_rvalid), 32'(prev_p1));
                check($sformatf("cont_p0_rvalid[%0d]", i), 32'(p0_rvalid), 32'(!prev_p1));
            end
            if (i < 9) cyc();
        end

        // Cycle 9 is a port-1 grant in both builds: reset it in flight.
        resetb = 1'b0;
        #1;
        check("midrst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        p0_req = 1'b0; p1_req = 1'b0;
        cyc();
        check("midrst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        resetb = 1'b1;
        cyc();
        check("postrst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single MMU data port (dm_* address/data/byte-enable/sign inputs, dm_do output) between two requesters.
- Port 0 is the pipeline load/store stage. Port 1 is a secondary master: the boot loader / debug memory access unit.
- The MMU has a fixed one-clock read latency. The arbiter grants combinationally in the request cycle and routes the returned data to the owning port one cycle later.
- Starvation of port 1 is bounded by an aging counter.

Parameters:
- MAX_WAIT, 4: consecutive cycles port 1 may be denied before it is forced to win; legal range 1..(2**WAIT_W - 1).
- WAIT_W, 3: width of the aging counter.

Ports:
- clk  in  1  clock, rising edge.
- resetb  in  1  asynchronous, active-low reset.
- p0_req, p1_req  in  1  access request, level, held until granted.
- p0_we, p1_we  in  1  write enable of request.
- p0_addr, p1_addr  in  32  byte address.
- p0_wdata, p1_wdata  in  32  write data, right-aligned.
- p0_be, p1_be  in  4  byte enable; 0000 is illegal while req=1.
- p0_signed, p1_signed  in  1  sign-extend loads.
- p0_gnt, p1_gnt  out  1  combinational grant; request consumed this cycle.
- p0_rvalid, p1_rvalid  out  1  registered; response for the access granted last cycle.
- p_rdata  out  32  dm_do passed through; valid only with an rvalid.
- mmu_we  out  1  to MMU dm_we.
- mmu_addr  out  32  to MMU dm_addr.
- mmu_di  out  32  to MMU dm_di.
- mmu_be  out  4  to MMU dm_be.
- mmu_signed  out  1  to MMU is_signed.
- mmu_do  in  32  from MMU dm_do.

Behaviour:
- Reset (async, resetb=0):
  - owner_p <= none, p0_rvalid=p1_rvalid=0, wait_cnt <= 0.
  - gnt outputs follow the combinational rule below; since the pending-response register is cleared, no rvalid can fire.
- Arbitration (combinational, same cycle):
  - If only one port requests, grant it.
  - If both request: grant port 1 when wait_cnt == MAX_WAIT; otherwise grant port 0.
  - At most one gnt is high per cycle.
- Idle cycle (no grant):
  - mmu_be=4'b0000 and mmu_we=0, so no BRAM bank is enabled and no IO strobe occurs.
  - mmu_addr, mmu_di and mmu_signed are driven to 0 (not X), to avoid spurious IO decode.
- Granted cycle: mmu_* carries the winner's fields unchanged. Byte-lane shifting stays in the MMU.
- Aging counter:
  - wait_cnt increments (saturating at MAX_WAIT) each cycle p1_req=1 and p1_gnt=0.
  - It clears on p1_gnt or when p1_req=0.
- Response:
  - owner_p registers the granted port index, or none.
  - Next cycle, the matching pN_rvalid=1 for both reads and writes; writes use it as an ack and p_rdata is ignored.
  - Back-to-back grants to alternating ports produce alternating rvalids with no bubble.
- Latency: request to rvalid is exactly 1 cycle when granted immediately. For a denied port, it is 1 cycle after the eventual grant.
- Requester rules:
  - A requester must not change its fields while req=1 and gnt=0. The arbiter does not check this.
  - Dropping req before gnt is legal (abandon). It clears wait_cnt for port 1.
- Reset mid-operation: an in-flight response is discarded and no rvalid is issued. Requesters restart after reset.

Optional Feature:
- Macro DMEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - The aging counter is removed.
  - A last_winner flop (reset to port 1, so port 0 wins first contention) gives the conflicted grant to the port that did not win the previous contended cycle.
  - Uncontended grants do not update last_winner.
- Undefined: fixed priority with MAX_WAIT aging as above.

Decomposition:
- Shared package constants: PORT_P0=0, PORT_P1=1, PORT_NONE encoding (2-bit owner), BE_NONE=4'b0000.
- Natural sub-module: dmem_arb_policy. It contains the grant logic plus either wait_cnt or last_winner, depending on the macro.
- The top level holds the mux and the response-routing flop.

Test Plan:
- Reset: hold resetb=0 with both req=1 → p0_rvalid=p1_rvalid=0 → release: p0_gnt=1 first cycle, p0_rvalid=1 next cycle.
- Solo read: p1 reads 0x10000010 be=1111 → p1_gnt same cycle, mmu_addr=0x10000010, p1_rvalid next cycle, p_rdata=stored word.
- Starvation, MAX_WAIT=4: both req continuously → grants P0,P0,P0,P0,P1,P0,P0,P0,P0,P1 …; wait_cnt never exceeds 4.
- Idle: no req → mmu_be=0000, mmu_we=0, mmu_addr=0; no IO access at 0x80000000.
- Write then read alternating ports: p0 writes 0xDEADBEEF to 0x10000020, p1 reads it the next cycle → p0_rvalid cycle 1, p1_rvalid cycle 2 with p_rdata=0xDEADBEEF.
- DMEM_ARB_ROUND_ROBIN_EN defined, both req continuously → grants P0,P1,P0,P1; async reset during a p1 grant → no p1_rvalid afterwards.
